// File: rtl/booth_multiplier_64_pkg.sv
// Shared definitions for the radix-2 Booth multiplier.
//   WIDTH_DEF  : default operand width
//   ST_*       : FSM state encodings (2'd3 is unused and recovers to idle)
//   booth_sel_e: per-step addend choice
//   booth_sel(): maps the {Q[0], q_m1} bit pair to an addend choice
package booth_multiplier_64_pkg;

   localparam int WIDTH_DEF = 64;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      SEL_NOP    = 2'd0,
      SEL_ADD_M  = 2'd1,
      SEL_ADD_NM = 2'd2
   } booth_sel_e;

   // 01 = end of a run of ones -> +M; 10 = start of a run -> -M
   function automatic booth_sel_e booth_sel(input logic q0, input logic q_m1);
      case ({q0, q_m1})
         2'b01:   return SEL_ADD_M;
         2'b10:   return SEL_ADD_NM;
         default: return SEL_NOP;
      endcase
   endfunction

endpackage

// File: rtl/booth_multiplier_64_booth_step.sv
// One combinational radix-2 Booth iteration: add 0/M/NM to ACC, then
// arithmetic-shift {sum, Q, q_m1} right by one.
//   acc_i/q_i/q_m1_i : current partial-product state
//   m_i/nm_i         : sign-extended multiplicand and its negation
//   acc_o/q_o/q_m1_o : state after the add and shift
module booth_step
   import booth_multiplier_64_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH:0]   acc_i,
   input  logic [WIDTH-1:0] q_i,
   input  logic             q_m1_i,
   input  logic [WIDTH:0]   m_i,
   input  logic [WIDTH:0]   nm_i,
   output logic [WIDTH:0]   acc_o,
   output logic [WIDTH-1:0] q_o,
   output logic             q_m1_o
);

   logic [WIDTH:0] addend;
   logic [WIDTH:0] sum;

   always_comb begin
      addend = '0;
      case (booth_sel(q_i[0], q_m1_i))
         SEL_ADD_M:  addend = m_i;
         SEL_ADD_NM: addend = nm_i;
         default:    addend = '0;
      endcase
      // Carry out of the guard bit is dropped on purpose.
      sum    = acc_i + addend;
      acc_o  = {sum[WIDTH], sum[WIDTH:1]};
      q_o    = {sum[0], q_i[WIDTH-1:1]};
      q_m1_o = q_i[0];
   end

endmodule

// File: rtl/booth_multiplier_64.sv
// Sequential signed radix-2 Booth multiplier, one step per clock.
//   clk, rst          : clock, synchronous active-high reset
//   start, a, b       : request and signed operands, taken when not busy
//   busy              : high while iterating
//   done              : one-cycle pulse when prod_hi/prod_lo are updated
//   prod_hi, prod_lo  : 2*WIDTH-bit signed product, held until next result
module booth_multiplier_64
   import booth_multiplier_64_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] prod_hi,
   output logic [WIDTH-1:0] prod_lo
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   logic [1:0]       state_q,   state_d;
   logic [WIDTH:0]   m_q,       m_d;
   logic [WIDTH:0]   nm_q,      nm_d;
   logic [WIDTH:0]   acc_q,     acc_d;
   logic [WIDTH-1:0] q_q,       q_d;
   logic             q_m1_q,    q_m1_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;
   logic [WIDTH-1:0] prod_hi_q, prod_hi_d;
   logic [WIDTH-1:0] prod_lo_q, prod_lo_d;

   logic [WIDTH:0]   a_ext;
   logic [WIDTH:0]   acc_nx;
   logic [WIDTH-1:0] q_nx;
   logic             q_m1_nx;

   // Guard bit lets -2^(WIDTH-1) be negated without overflow.
   assign a_ext = {a[WIDTH-1], a};

   booth_step #(.WIDTH(WIDTH)) u_step (
      .acc_i  (acc_q),
      .q_i    (q_q),
      .q_m1_i (q_m1_q),
      .m_i    (m_q),
      .nm_i   (nm_q),
      .acc_o  (acc_nx),
      .q_o    (q_nx),
      .q_m1_o (q_m1_nx)
   );

   always_comb begin
      state_d   = state_q;
      m_d       = m_q;
      nm_d      = nm_q;
      acc_d     = acc_q;
      q_d       = q_q;
      q_m1_d    = q_m1_q;
      cnt_d     = cnt_q;
      prod_hi_d = prod_hi_q;
      prod_lo_d = prod_lo_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            // DONE accepts a new request just like IDLE (back-to-back).
            if (start) begin
               m_d     = a_ext;
               nm_d    = ~a_ext + {{WIDTH{1'b0}}, 1'b1};
               acc_d   = '0;
               q_d     = b;
               q_m1_d  = 1'b0;
               cnt_d   = CNT_W'(WIDTH);
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            acc_d  = acc_nx;
            q_d    = q_nx;
            q_m1_d = q_m1_nx;
            cnt_d  = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d   = ST_DONE;
               prod_hi_d = acc_nx[WIDTH-1:0];
               prod_lo_d = q_nx;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         m_q       <= '0;
         nm_q      <= '0;
         acc_q     <= '0;
         q_q       <= '0;
         q_m1_q    <= 1'b0;
         cnt_q     <= '0;
         prod_hi_q <= '0;
         prod_lo_q <= '0;
      end else begin
         state_q   <= state_d;
         m_q       <= m_d;
         nm_q      <= nm_d;
         acc_q     <= acc_d;
         q_q       <= q_d;
         q_m1_q    <= q_m1_d;
         cnt_q     <= cnt_d;
         prod_hi_q <= prod_hi_d;
         prod_lo_q <= prod_lo_d;
      end
   end

   assign busy    = (state_q == ST_RUN);
   assign done    = (state_q == ST_DONE);
   assign prod_hi = prod_hi_q;
   assign prod_lo = prod_lo_q;

endmodule

// File: tb/tb_booth_multiplier_64.sv
module tb_booth_multiplier_64;

   localparam int W = 64;
   localparam logic [W-1:0] MIN_V = 64'h8000_0000_0000_0000;
   localparam logic [W-1:0] MAX_V = 64'h7FFF_FFFF_FFFF_FFFF;
   localparam logic [W-1:0] NEG1  = 64'hFFFF_FFFF_FFFF_FFFF;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy, done;
   logic [W-1:0] prod_hi, prod_lo;

   int compared = 0;
   int mismatched = 0;
   int done_seen = 0;
   int exp_done = 0;

   booth_multiplier_64 dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .prod_hi(prod_hi), .prod_lo(prod_lo)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (done) done_seen++;

   typedef struct {
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic [2*W-1:0] p;
   } vec_t;

   vec_t tbl [0:8];

   task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: plain 128-bit signed multiply.
   function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
      logic signed [2*W-1:0] sx, sy;
      sx = $signed({{W{x[W-1]}}, x});
      sy = $signed({{W{y[W-1]}}, y});
      return sx * sy;
   endfunction

   // Present a request for one edge. When now=1 the caller is already at the
   // negedge where it wants start driven (e.g. the DONE cycle).
   task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input bit now);
      if (!now) @(negedge clk);
      a = x; b = y; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      a = $urandom; b = $urandom;   // operands may change after accept
      exp_done++;
   endtask

   // Counts edges after the accept edge until done; inj_at >= 0 injects an
   // ignored start (9*9) at that cycle.
   task automatic wait_done(input int inj_at, output int lat, output int bcnt);
      int n;
      n = 0; bcnt = 0;
      while (!done && n < 200) begin
         if (busy) bcnt++;
         if (n == inj_at) begin a = 9; b = 9; start = 1'b1; end
         else start = 1'b0;
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      lat = done ? n : -1;
   endtask

   initial begin
      int lat, bcnt, seen0;
      logic [W-1:0] x, y;

      tbl[0] = '{64'd3,   64'd5,   128'd15};
      tbl[1] = '{-64'sd7, 64'd6,   {NEG1, 64'hFFFF_FFFF_FFFF_FFD6}};
      tbl[2] = '{MIN_V,   MIN_V,   {64'h4000_0000_0000_0000, 64'h0}};
      tbl[3] = '{MIN_V,   NEG1,    {64'h0, MIN_V}};
      tbl[4] = '{MAX_V,   MAX_V,   {64'h3FFF_FFFF_FFFF_FFFF, 64'h1}};
      tbl[5] = '{MIN_V,   MAX_V,   {64'hC000_0000_0000_0000, MIN_V}};
      tbl[6] = '{NEG1,    NEG1,    128'd1};
      tbl[7] = '{64'd0,   NEG1,    128'd0};
      tbl[8] = '{64'd1234, 64'd5678, 128'd7006652};

      repeat (3) @(negedge clk);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_prod", {prod_hi, prod_lo}, 0);
      rst = 1'b0;

      for (int i = 0; i < 9; i++) begin
         launch(tbl[i].a, tbl[i].b, 0);
         wait_done(-1, lat, bcnt);
         chk($sformatf("tbl%0d_lat", i), lat, W);
         chk($sformatf("tbl%0d_busy", i), bcnt, W);
         chk($sformatf("tbl%0d_prod", i), {prod_hi, prod_lo}, tbl[i].p);
      end
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("prod_hold_idle", {prod_hi, prod_lo}, 128'd7006652);

      // Start ignored while busy, then back-to-back accept in DONE cycle.
      launch(64'd2, 64'd3, 0);
      wait_done(20, lat, bcnt);
      chk("ign_lat", lat, W);
      chk("ign_prod", {prod_hi, prod_lo}, 128'd6);
      launch(64'd9, 64'd9, 1);
      chk("b2b_busy", busy, 1);
      chk("b2b_prod_stable", {prod_hi, prod_lo}, 128'd6);
      wait_done(-1, lat, bcnt);
      chk("b2b_lat", lat, W);
      chk("b2b_prod", {prod_hi, prod_lo}, 128'd81);

      // Reset mid-operation aborts.
      launch(64'd1234, 64'd5678, 0);
      exp_done--;
      repeat (29) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_prod", {prod_hi, prod_lo}, 0);
      seen0 = done_seen;
      repeat (80) @(negedge clk);
      chk("abort_no_done", done_seen - seen0, 0);
      launch(64'd1234, 64'd5678, 0);
      wait_done(-1, lat, bcnt);
      chk("after_abort_prod", {prod_hi, prod_lo}, 128'd7006652);

      // Random pairs, chained back-to-back through the DONE cycle.
      for (int i = 0; i < 1000; i++) begin
         x = {$urandom, $urandom};
         y = {$urandom, $urandom};
         case ($urandom_range(0, 7))
            0: x = MIN_V;
            1: y = ($urandom_range(0, 1) != 0) ? MIN_V : NEG1;
            2: x = MAX_V;
            default: ;
         endcase
         launch(x, y, i != 0);
         wait_done(-1, lat, bcnt);
         chk($sformatf("rnd%0d_lat", i), lat, W);
         chk($sformatf("rnd%0d_prod a=%h b=%h", i, x, y), {prod_hi, prod_lo}, ref_mul(x, y));
      end
      @(negedge clk);
      chk("done_count", done_seen, exp_done);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
